// File: rtl/histogram_pkg.sv
// Shared definitions for the histogram sequencing controller.
package histogram_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRx    = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  // States in which a frame is in progress.
  function automatic logic is_busy(state_e st);
    return (st == StClear) || (st == StRx) || (st == StDrain) || (st == StDone);
  endfunction

endpackage

// File: rtl/histogram_wdog.sv
// Down-counting watchdog: expires on the P_TO-th enabled cycle after a load.
module histogram_wdog #(
  parameter int unsigned P_TO = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(P_TO + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down while enabled, saturating at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(P_TO);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == CntW'(1));

endmodule

// File: rtl/histogram_seq_ctrl.sv
// Frame sequencer for a histogram engine: clears bins, gates the input stream,
// waits for the result drain and reports completion and error conditions.
module histogram_seq_ctrl
  import histogram_pkg::*;
#(
  parameter int unsigned P_NUM_BIN = 8,
  parameter int unsigned P_LEN_W   = 16,
  parameter int unsigned P_TO      = 1024,
  localparam int unsigned AddrW    = (P_NUM_BIN > 1) ? $clog2(P_NUM_BIN) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic               cfg_auto,
  input  logic               cfg_irq_en,
  input  logic [P_LEN_W-1:0] cfg_frame_len,
  input  logic               rx_beat,
  input  logic               rx_last,
  input  logic               tx_beat,
  input  logic               tx_last,
  input  logic               irq_ack,
  input  logic               err_clr,
  output logic               rx_enable,
  output logic               clr_en,
  output logic [AddrW-1:0]   clr_addr,
  output logic               busy,
  output logic [StateW-1:0]  state,
  output logic [15:0]        frame_cnt,
  output logic               err_short,
  output logic               err_long,
  output logic               err_cfg,
  output logic               err_to,
  output logic               irq
);

  localparam logic [AddrW-1:0] LastAddr = AddrW'(P_NUM_BIN - 1);

  state_e             state_q, state_d;
  logic [P_LEN_W-1:0] len_q, len_d;
  logic               auto_q, auto_d;
  logic               irq_en_q, irq_en_d;
  logic [P_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [AddrW-1:0]   clr_addr_q, clr_addr_d;
  logic               clr_en_q, clr_en_d;
  logic               rx_enable_q, rx_enable_d;
  logic               busy_q, busy_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;
  logic               err_cfg_q, err_cfg_d;
  logic               err_to_q, err_to_d;
  logic               irq_q, irq_d;
  logic               irq_set;
  logic               wdog_load;
  logic               wdog_expire;
  logic [P_LEN_W:0]   beat_next;
  logic               abort_hit;

  assign beat_next = {1'b0, beat_cnt_q} + {{P_LEN_W{1'b0}}, 1'b1};
  assign abort_hit = cfg_abort && (state_q != StIdle) && (state_q != StErr);

  histogram_wdog #(
    .P_TO (P_TO)
  ) u_wdog (
    .clk_i    (aclk),
    .rst_i    (areset),
    .load_i   (wdog_load),
    .en_i     (state_q == StDrain),
    .expire_o (wdog_expire)
  );

  // Next-state, counters, sticky flags and registered-output precomputation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    auto_d      = auto_q;
    irq_en_d    = irq_en_q;
    beat_cnt_d  = beat_cnt_q;
    clr_addr_d  = '0;
    frame_cnt_d = frame_cnt_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    err_cfg_d   = err_cfg_q;
    err_to_d    = err_to_q;
    irq_set     = 1'b0;
    wdog_load   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Abort outranks start even though abort has nothing to cancel here.
        if (cfg_start && !cfg_abort) begin
          len_d    = cfg_frame_len;
          auto_d   = cfg_auto;
          irq_en_d = cfg_irq_en;
          if (cfg_frame_len == '0) begin
            state_d   = StErr;
            err_cfg_d = 1'b1;
          end else begin
            state_d = StClear;
          end
        end
      end
      StClear: begin
        clr_addr_d = clr_addr_q + AddrW'(1);
        beat_cnt_d = '0;
        if (clr_addr_q == LastAddr) begin
          state_d = StRx;
        end
      end
      StRx: begin
        if (rx_beat) begin
          if (rx_last) begin
            state_d   = StDrain;
            wdog_load = 1'b1;
            if (beat_next < {1'b0, len_q}) begin
              err_short_d = 1'b1;
            end
          end else if (beat_next == {1'b0, len_q}) begin
            state_d    = StDrain;
            wdog_load  = 1'b1;
            err_long_d = 1'b1;
          end else begin
            beat_cnt_d = beat_next[P_LEN_W-1:0];
          end
        end
      end
      StDrain: begin
        if (tx_beat && tx_last) begin
          state_d     = StDone;
          frame_cnt_d = frame_cnt_q + 16'd1;
          irq_set     = irq_en_q;
        end else if (wdog_expire) begin
          state_d  = StErr;
          err_to_d = 1'b1;
        end
      end
      StDone: begin
        state_d = auto_q ? StClear : StIdle;
      end
      StErr: begin
        if (err_clr) begin
          state_d     = StIdle;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          err_cfg_d   = 1'b0;
          err_to_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort discards whatever the current cycle would have recorded.
    if (abort_hit) begin
      state_d     = StIdle;
      frame_cnt_d = frame_cnt_q;
      err_short_d = err_short_q;
      err_long_d  = err_long_q;
      err_to_d    = err_to_q;
      irq_set     = 1'b0;
      wdog_load   = 1'b0;
    end

    if (state_d != StClear) begin
      clr_addr_d = '0;
    end

    // A new interrupt beats a simultaneous acknowledge.
    irq_d       = irq_set | (irq_q & ~irq_ack);
    clr_en_d    = (state_d == StClear);
    rx_enable_d = (state_d == StRx);
    busy_d      = is_busy(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      auto_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      beat_cnt_q  <= '0;
      clr_addr_q  <= '0;
      clr_en_q    <= 1'b0;
      rx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_to_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      auto_q      <= auto_d;
      irq_en_q    <= irq_en_d;
      beat_cnt_q  <= beat_cnt_d;
      clr_addr_q  <= clr_addr_d;
      clr_en_q    <= clr_en_d;
      rx_enable_q <= rx_enable_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_cfg_q   <= err_cfg_d;
      err_to_q    <= err_to_d;
      irq_q       <= irq_d;
    end
  end

  assign state     = state_q;
  assign rx_enable = rx_enable_q;
  assign clr_en    = clr_en_q;
  assign clr_addr  = clr_addr_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign err_cfg   = err_cfg_q;
  assign err_to    = err_to_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_histogram_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected state-transition snapshots and
// clear addresses; a monitor compares them as the DUT presents them.
module tb_histogram_seq_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_start, cfg_abort, cfg_auto, cfg_irq_en;
  logic [15:0] cfg_frame_len;
  logic        rx_beat, rx_last, tx_beat, tx_last, irq_ack, err_clr;
  logic        rx_enable, clr_en, busy;
  logic [2:0]  clr_addr;
  logic [2:0]  state;
  logic [15:0] frame_cnt;
  logic        err_short, err_long, err_cfg, err_to, irq;

  typedef struct {
    logic [25:0] v;
    int          dwell;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] clr_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic       mon_on   = 1'b0;

  histogram_seq_ctrl #(
    .P_NUM_BIN (8),
    .P_LEN_W   (16),
    .P_TO      (16)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_auto      (cfg_auto),
    .cfg_irq_en    (cfg_irq_en),
    .cfg_frame_len (cfg_frame_len),
    .rx_beat       (rx_beat),
    .rx_last       (rx_last),
    .tx_beat       (tx_beat),
    .tx_last       (tx_last),
    .irq_ack       (irq_ack),
    .err_clr       (err_clr),
    .rx_enable     (rx_enable),
    .clr_en        (clr_en),
    .clr_addr      (clr_addr),
    .busy          (busy),
    .state         (state),
    .frame_cnt     (frame_cnt),
    .err_short     (err_short),
    .err_long      (err_long),
    .err_cfg       (err_cfg),
    .err_to        (err_to),
    .irq           (irq)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {state, busy, rx_enable, frame_cnt, err_short, err_long, err_cfg, err_to, irq}
  function automatic logic [25:0] pk(input logic [2:0] st, input logic b, input logic r,
                                     input logic [15:0] fc, input logic es, input logic el,
                                     input logic ec, input logic et, input logic iq);
    return {st, b, r, fc, es, el, ec, et, iq};
  endfunction

  task automatic exp_st(input string name, input logic [25:0] v, input int dwell);
    exp_t e;
    e.v     = v;
    e.dwell = dwell;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_clear();
    for (int i = 0; i < 8; i++) begin
      clr_q.push_back(3'(i));
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [2:0] tgt, input int max);
    for (int i = 0; i < max; i++) begin
      if (state == tgt) break;
      tick();
    end
    chk(name, 32'(state), 32'(tgt));
  endtask

  task automatic start(input logic [15:0] len, input logic au, input logic ie);
    cfg_frame_len = len;
    cfg_auto      = au;
    cfg_irq_en    = ie;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic beats(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      rx_beat = 1'b1;
      rx_last = last_on_final && (i == n - 1);
      tick();
    end
    rx_beat = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic drain_done(input logic ack);
    tx_beat = 1'b1;
    tx_last = 1'b0;
    tick();
    tx_last = 1'b1;
    irq_ack = ack;
    tick();
    tx_beat = 1'b0;
    tx_last = 1'b0;
    irq_ack = 1'b0;
  endtask

  // Monitor: compares clear strobes and every state change against the queues.
  initial begin
    logic [2:0] prev_st;
    int         dwell;
    prev_st = 3'd0;
    dwell   = 1;
    forever begin
      @(negedge aclk);
      if (mon_on) begin
        if (clr_en) begin
          if (clr_q.size() == 0) begin
            chk("clr_unexpected", 32'(clr_addr), 32'hFFFF_FFFF);
          end else begin
            chk("clr_addr", 32'(clr_addr), 32'(clr_q.pop_front()));
          end
        end
        if (state != prev_st) begin
          if (exp_q.size() == 0) begin
            chk("state_unexpected", 32'(state), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, 32'(pk(state, busy, rx_enable, frame_cnt, err_short, err_long,
                               err_cfg, err_to, irq)), 32'(e.v));
            if (e.dwell >= 0) chk({e.name, "_dwell"}, 32'(dwell), 32'(e.dwell));
          end
          prev_st = state;
          dwell   = 1;
        end else begin
          dwell++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    {cfg_start, cfg_abort, cfg_auto, cfg_irq_en} = '0;
    cfg_frame_len = '0;
    {rx_beat, rx_last, tx_beat, tx_last, irq_ack, err_clr} = '0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({rx_enable, clr_en, clr_addr, busy}), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_flags", 32'({err_short, err_long, err_cfg, err_to, irq}), 32'd0);
    areset = 1'b0;
    mon_on = 1'b1;
    tick();

    // Nominal frame, irq set beats a simultaneous ack.
    exp_st("s1_clear", pk(3'd1, 1, 0, 16'd0, 0, 0, 0, 0, 0), -1);
    exp_clear();
    exp_st("s1_rx",    pk(3'd2, 1, 1, 16'd0, 0, 0, 0, 0, 0), 8);
    exp_st("s1_drain", pk(3'd3, 1, 0, 16'd0, 0, 0, 0, 0, 0), -1);
    exp_st("s1_done",  pk(3'd4, 1, 0, 16'd1, 0, 0, 0, 0, 1), -1);
    exp_st("s1_idle",  pk(3'd0, 0, 0, 16'd1, 0, 0, 0, 0, 1), 1);
    start(16'd4, 1'b0, 1'b1);
    wait_state("s1_wait_rx", 3'd2, 20);
    beats(4, 1'b1);
    drain_done(1'b1);
    wait_state("s1_wait_idle", 3'd0, 10);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("s1_irq_ack", 32'(irq), 32'd0);

    // Short frame.
    exp_st("s2_clear", pk(3'd1, 1, 0, 16'd1, 0, 0, 0, 0, 0), -1);
    exp_clear();
    exp_st("s2_rx",    pk(3'd2, 1, 1, 16'd1, 0, 0, 0, 0, 0), 8);
    exp_st("s2_drain", pk(3'd3, 1, 0, 16'd1, 1, 0, 0, 0, 0), 2);
    exp_st("s2_done",  pk(3'd4, 1, 0, 16'd2, 1, 0, 0, 0, 0), -1);
    exp_st("s2_idle",  pk(3'd0, 0, 0, 16'd2, 1, 0, 0, 0, 0), 1);
    start(16'd4, 1'b0, 1'b0);
    wait_state("s2_wait_rx", 3'd2, 20);
    beats(2, 1'b1);
    drain_done(1'b0);
    wait_state("s2_wait_idle", 3'd0, 10);

    // Long frame: length reached without last.
    exp_st("s3_clear", pk(3'd1, 1, 0, 16'd2, 1, 0, 0, 0, 0), -1);
    exp_clear();
    exp_st("s3_rx",    pk(3'd2, 1, 1, 16'd2, 1, 0, 0, 0, 0), 8);
    exp_st("s3_drain", pk(3'd3, 1, 0, 16'd2, 1, 1, 0, 0, 0), 3);
    exp_st("s3_done",  pk(3'd4, 1, 0, 16'd3, 1, 1, 0, 0, 0), -1);
    exp_st("s3_idle",  pk(3'd0, 0, 0, 16'd3, 1, 1, 0, 0, 0), 1);
    start(16'd3, 1'b0, 1'b0);
    wait_state("s3_wait_rx", 3'd2, 20);
    beats(3, 1'b0);
    chk("s3_rx_enable_low", 32'(rx_enable), 32'd0);
    drain_done(1'b0);
    wait_state("s3_wait_idle", 3'd0, 10);

    // Drain timeout, then error clear.
    exp_st("s4_clear", pk(3'd1, 1, 0, 16'd3, 1, 1, 0, 0, 0), -1);
    exp_clear();
    exp_st("s4_rx",    pk(3'd2, 1, 1, 16'd3, 1, 1, 0, 0, 0), 8);
    exp_st("s4_drain", pk(3'd3, 1, 0, 16'd3, 1, 1, 0, 0, 0), 2);
    exp_st("s4_err",   pk(3'd5, 0, 0, 16'd3, 1, 1, 0, 1, 0), 16);
    exp_st("s4_idle",  pk(3'd0, 0, 0, 16'd3, 0, 0, 0, 0, 0), -1);
    start(16'd2, 1'b0, 1'b0);
    wait_state("s4_wait_rx", 3'd2, 20);
    beats(2, 1'b1);
    wait_state("s4_wait_err", 3'd5, 40);
    repeat (2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wait_state("s4_wait_idle", 3'd0, 10);

    // Auto restart, abort with start mid-RX, then zero-length start.
    exp_st("s5_clear",  pk(3'd1, 1, 0, 16'd3, 0, 0, 0, 0, 0), -1);
    exp_clear();
    exp_st("s5_rx",     pk(3'd2, 1, 1, 16'd3, 0, 0, 0, 0, 0), 8);
    exp_st("s5_drain",  pk(3'd3, 1, 0, 16'd3, 0, 0, 0, 0, 0), 2);
    exp_st("s5_done",   pk(3'd4, 1, 0, 16'd4, 0, 0, 0, 0, 1), -1);
    exp_st("s5_clear2", pk(3'd1, 1, 0, 16'd4, 0, 0, 0, 0, 1), 1);
    exp_clear();
    exp_st("s5_rx2",    pk(3'd2, 1, 1, 16'd4, 0, 0, 0, 0, 1), 8);
    exp_st("s5_abort",  pk(3'd0, 0, 0, 16'd4, 0, 0, 0, 0, 1), 2);
    exp_st("s5_cfgerr", pk(3'd5, 0, 0, 16'd4, 0, 0, 1, 0, 1), -1);
    exp_st("s5_idle",   pk(3'd0, 0, 0, 16'd4, 0, 0, 0, 0, 1), -1);
    start(16'd2, 1'b1, 1'b1);
    wait_state("s5_wait_rx", 3'd2, 20);
    beats(2, 1'b1);
    drain_done(1'b0);
    wait_state("s5_wait_rx2", 3'd2, 20);
    beats(1, 1'b0);
    cfg_abort     = 1'b1;
    cfg_start     = 1'b1;
    cfg_frame_len = 16'd7;
    tick();
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    chk("s5_abort_state", 32'(state), 32'd0);
    tick();
    start(16'd0, 1'b0, 1'b0);
    wait_state("s5_wait_err", 3'd5, 5);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wait_state("s5_wait_idle", 3'd0, 5);

    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("clr_q_drained", 32'(clr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/histogram_seq_ctrl.md
HISTOGRAM_SEQ_CTRL -- requirements
Module: histogram_seq_ctrl

Interface
REQ-001 SHALL have parameters: P_NUM_BIN, default 8, number of bins to clear; P_LEN_W, default 16, frame-length width; P_TO, default 1024, drain-timeout cycles.
REQ-002 SHALL have ports: aclk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have ports: areset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: cfg_start  in  1, start pulse; cfg_abort  in  1, abort pulse; cfg_auto  in  1, auto-restart; cfg_irq_en  in  1, interrupt enable; cfg_frame_len  in  P_LEN_W, expected beats per frame.
REQ-005 SHALL have ports: rx_beat  in  1, rvalid&&rready seen; rx_last  in  1, rlast on that beat; tx_beat  in  1, tvalid&&tready seen; tx_last  in  1, tlast on that beat.
REQ-006 SHALL have ports: irq_ack  in  1, clears irq; err_clr  in  1, leaves ERR.
REQ-007 SHALL have ports: rx_enable  out  1, gates upstream rready; clr_en  out  1, bin-clear strobe; clr_addr  out  clog2(P_NUM_BIN), bin being cleared.
REQ-008 SHALL have ports: busy  out  1; state  out  3; frame_cnt  out  16, completed frames; err_short, err_long, err_cfg, err_to  out  1 each, sticky; irq  out  1, sticky.

Function
REQ-009 SHALL encode states IDLE=0, CLEAR=1, RX=2, DRAIN=3, DONE=4, ERR=5; state output = current state.
REQ-010 SHALL, in IDLE on cfg_start, latch cfg_frame_len/cfg_auto/cfg_irq_en; go to CLEAR next cycle, or to ERR with err_cfg=1 if cfg_frame_len==0.
REQ-011 SHALL, in CLEAR, assert clr_en for exactly P_NUM_BIN cycles with clr_addr 0,1,...,P_NUM_BIN-1, then enter RX.
REQ-012 SHALL assert rx_enable only in RX; beat counter reset to 0 on RX entry, increments per rx_beat.
REQ-013 SHALL, on rx_beat with rx_last, enter DRAIN; set err_short if counter+1 < latched length.
REQ-014 SHALL, on rx_beat with counter+1 == latched length and rx_last=0, set err_long and enter DRAIN.
REQ-015 SHALL, in DRAIN, enter DONE on tx_beat&&tx_last; enter ERR with err_to=1 if P_TO cycles pass without it.
REQ-016 SHALL spend one cycle in DONE: frame_cnt increments (wraps 0xFFFF->0), irq sets if latched irq_en; next state CLEAR if latched auto else IDLE.
REQ-017 SHALL hold ERR until err_clr, then go to IDLE and clear all err_* flags.
REQ-018 SHALL ignore cfg_start when not IDLE; cfg_abort in any state except IDLE/ERR forces IDLE next cycle, frame_cnt unchanged.
REQ-019 SHALL give priority abort > start when both asserted; irq set wins over irq_ack in the same cycle.
REQ-020 SHALL drive busy=1 in CLEAR, RX, DRAIN, DONE; 0 in IDLE, ERR.
REQ-021 SHALL make every output registered; rx_enable deasserts the cycle after the terminating beat or abort.

Reset
REQ-022 SHALL on areset: state IDLE, rx_enable 0, clr_en 0, clr_addr 0, busy 0, frame_cnt 0, all err_* 0, irq 0, latched config 0.
REQ-023 SHALL abandon any in-progress frame on areset, with no pulses emitted on release.

Structure
REQ-024 SHALL place state encoding constants and the 3-bit state width in shared package histogram_pkg.
REQ-025 SHALL implement the DRAIN timeout as sub-module histogram_wdog (load/enable/expire, width clog2(P_TO+1)).

Verification
REQ-026 len=4, auto=0: start, 4 beats, last on 4th, tx_last -> CLEAR 8 cycles with addr 0..7, DONE, frame_cnt=1, irq=1, IDLE.
REQ-027 len=4: rx_last on beat 2 -> err_short=1, DRAIN; no err_long.
REQ-028 len=3: 3 beats, rx_last=0 -> err_long=1, rx_enable low next cycle.
REQ-029 P_TO=16: no tx_last in DRAIN -> ERR on cycle 16, err_to=1; err_clr -> IDLE, flags 0.
REQ-030 auto=1, abort+start same cycle mid-RX -> IDLE next cycle, frame_cnt unchanged; start with len=0 -> ERR, err_cfg=1.
